mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the fetch stage (instruction
//  reads) and the memory stage (loads/stores) of the 5-stage pipelined MIPS core.
//  Sequences each access with a req/ack handshake, buffers completed results and
//  drives a global stall to the pipeline registers until every pending access of the
//  current cycle has completed. Sits between the datapath and the external memory.
// PARAMETERS
//  WIDTH     32  data and address width
//  MAX_WAIT  15  cycles without mem_ack before an access is aborted (timeout)
//  WAIT_W    4   width of the wait counter; must hold MAX_WAIT
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  ireq       in   1      fetch stage needs an instruction this cycle
//  iaddr      in   WIDTH  fetch address (PCF)
//  irdata     out  WIDTH  fetched instruction, valid while ivalid=1
//  ivalid     out  1      instruction buffer holds the word for iaddr
//  dreq       in   1      memory stage performs a load or store
//  dwe        in   1      1 = store, 0 = load
//  daddr      in   WIDTH  data address (aluoutM)
//  dwdata     in   WIDTH  store data (writedataM)
//  drdata     out  WIDTH  load data, valid while dvalid=1
//  dvalid     out  1      data access complete
//  stall      out  1      freeze F/D/E/M pipeline registers this cycle
//  mem_req    out  1      memory request, held until acknowledged
//  mem_we     out  1      memory write enable
//  mem_addr   out  WIDTH  memory address
//  mem_wdata  out  WIDTH  memory write data
//  mem_ack    in   1      memory completed the request this cycle
//  mem_rdata  in   WIDTH  memory read data, sampled with mem_ack
//  err        out  1      sticky timeout flag
//  stall_cnt  out  32     count of cycles with stall=1, wraps at 2^32
// BEHAVIOUR
//  - Reset: state IDLE; mem_req, mem_we, ivalid, dvalid, err = 0; mem_addr, mem_wdata,
//    irdata, drdata, stall_cnt, wait counter = 0. stall is combinational (below).
//  - Pending: pend_d = dreq & ~dvalid; pend_i = ireq & ~ivalid.
//  - stall = pend_d | pend_i (combinational, also high in the cycle a done flag is set
//    only if the other side is still pending).
//  - FSM states IDLE, IBUSY, DBUSY. Memory-side outputs are registered.
//  - IDLE: if pend_d -> DBUSY, load mem_addr=daddr, mem_we=dwe, mem_wdata=dwdata, mem_req=1;
//    else if pend_i -> IBUSY, mem_addr=iaddr, mem_we=0, mem_req=1. Data has priority (older
//    instruction). mem_ack in IDLE is ignored.
//  - xBUSY: mem_req, mem_we, mem_addr, mem_wdata held stable. On mem_ack=1: capture
//    mem_rdata into drdata/irdata (store: drdata unchanged), set dvalid/ivalid, clear
//    mem_req/mem_we, wait counter to 0, return to IDLE. Otherwise wait counter +1.
//  - Timeout: wait counter reaches MAX_WAIT without ack -> set err (sticky until reset),
//    complete the access with captured data 0, return to IDLE, drop mem_req.
//  - Latency: request in cycle 0 -> mem_req in cycle 1; ack in cycle k -> valid in k+1.
//    One IDLE cycle separates consecutive accesses.
//  - Done flags ivalid/dvalid clear on any edge where stall=0 (pipeline advanced); a flag
//    is never set and cleared on the same edge. Buffered results are never re-requested.
//  - stall_cnt increments on every edge with stall=1.
//  - reset mid-access: returns to IDLE immediately; a later mem_ack for the aborted
//    access is ignored.
// STRUCTURE
//  - Package mem_arb_pkg: state encoding localparams (IDLE, IBUSY, DBUSY), MAX_WAIT default.
//  - Single module plus the existing flopenr for irdata/drdata capture registers;
//    no new sub-module.
// TESTING
//  - Fetch only: ireq=1, iaddr=0x00400000, ack 2 cycles after mem_req, rdata=0x20080005
//    -> mem_req cycles 1-3, ivalid + irdata=0x20080005 in cycle 4, stall high cycles 0-3.
//  - Simultaneous load+fetch: dreq=1, dwe=0, daddr=0x10010000 and ireq=1 in cycle 0 ->
//    data served first (mem_addr=0x10010000), then fetch; stall low only after both done.
//  - Store: dwe=1, daddr=0x10010004, dwdata=0xCAFEF00D, immediate ack -> mem_we=1,
//    mem_wdata=0xCAFEF00D for one cycle, dvalid next cycle, drdata unchanged.
//  - Timeout: mem_ack held 0 -> after 15 busy cycles err=1, mem_req=0, data=0, stall releases;
//    err remains 1 until reset.
//  - Reset mid-access: reset while in DBUSY, then ack arrives -> all outputs 0, no valid.
//  - stall_cnt: run 3 back-to-back fetches with 1-cycle memory -> stall_cnt equals number of
//    stall-high cycles counted by the bench.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_WAIT_DEF = 15;
    localparam int unsigned WAIT_W_DEF   = 4;
    localparam int unsigned STALL_CNT_W  = 32;

endpackage

// File: rtl/flopenr.sv
// Resettable flip-flop with load enable.
module flopenr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store accesses and
// stalls the pipeline until every access requested this cycle has completed.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
    parameter int unsigned WAIT_W   = WAIT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ireq,
    input  logic [WIDTH-1:0]       iaddr,
    output logic [WIDTH-1:0]       irdata,
    output logic                   ivalid,
    input  logic                   dreq,
    input  logic                   dwe,
    input  logic [WIDTH-1:0]       daddr,
    input  logic [WIDTH-1:0]       dwdata,
    output logic [WIDTH-1:0]       drdata,
    output logic                   dvalid,
    output logic                   stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic                   mem_ack,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic                   err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              pend_i;
    logic              pend_d;
    logic              timeout;
    logic              finish;
    logic              i_done;
    logic              d_done;
    logic [WIDTH-1:0]  cap_data;

    assign pend_d = dreq & ~dvalid;
    assign pend_i = ireq & ~ivalid;
    assign stall  = pend_d | pend_i;

    // An ack on the last allowed cycle still wins over the timeout.
    assign timeout  = ~mem_ack & (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign finish   = mem_ack | timeout;
    assign i_done   = (state == IBUSY) & finish;
    assign d_done   = (state == DBUSY) & finish;
    assign cap_data = mem_ack ? mem_rdata : '0;

    flopenr #(.WIDTH(WIDTH)) u_irdata (
        .clk   (clk),
        .reset (reset),
        .en    (i_done),
        .d     (cap_data),
        .q     (irdata)
    );

    // Stores leave the load result buffer untouched.
    flopenr #(.WIDTH(WIDTH)) u_drdata (
        .clk   (clk),
        .reset (reset),
        .en    (d_done & ~mem_we),
        .d     (cap_data),
        .q     (drdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ivalid    <= 1'b0;
            dvalid    <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);

            // Pipeline advanced: results have been consumed.
            if (!stall) begin
                ivalid <= 1'b0;
                dvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (pend_d) begin
                        state     <= DBUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dwe;
                        mem_addr  <= daddr;
                        mem_wdata <= dwdata;
                    end else if (pend_i) begin
                        state    <= IBUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= iaddr;
                    end
                end
                IBUSY, DBUSY: begin
                    if (finish) begin
                        if (state == IBUSY)
                            ivalid <= 1'b1;
                        else
                            dvalid <= 1'b1;
                        if (timeout)
                            err <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
